// File: rtl/seg_pkg.sv
// Shared constants and state type for the 7-segment scan decoder: legal segment
// codes (bits a..g, MSB = a), dp bit position and the capture FSM encoding.
package seg_pkg;

  localparam logic [6:0] SEG_CODE_0 = 7'b1111110;
  localparam logic [6:0] SEG_CODE_1 = 7'b0110000;
  localparam logic [6:0] SEG_CODE_2 = 7'b1101101;
  localparam logic [6:0] SEG_CODE_3 = 7'b1111001;
  localparam logic [6:0] SEG_CODE_4 = 7'b0110011;
  localparam logic [6:0] SEG_CODE_5 = 7'b1011011;
  localparam logic [6:0] SEG_CODE_6 = 7'b1011111;
  localparam logic [6:0] SEG_CODE_7 = 7'b1110000;

  localparam int SEG_DP_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_STABLE,
    CAPTURED
  } seg_state_e;

endpackage

// File: rtl/seg_to_bin.sv
// Combinational 7-segment pattern to 3-bit value decoder with a legal-code flag.
module seg_to_bin
  import seg_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [2:0] val_o,
  output logic       legal_o
);

  always_comb begin
    val_o   = 3'd0;
    legal_o = 1'b1;
    unique case (pat_i)
      SEG_CODE_0: val_o = 3'd0;
      SEG_CODE_1: val_o = 3'd1;
      SEG_CODE_2: val_o = 3'd2;
      SEG_CODE_3: val_o = 3'd3;
      SEG_CODE_4: val_o = 3'd4;
      SEG_CODE_5: val_o = 3'd5;
      SEG_CODE_6: val_o = 3'd6;
      SEG_CODE_7: val_o = 3'd7;
      default:    legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reconstructs per-digit values from a multiplexed 7-segment bus with a stability
// filter and sticky error flags. Define SEG_ACTIVE_LOW_EN for common-anode polarity.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   com_in,
  input  logic                    err_clr,
  output logic [3*NUM_DIGITS-1:0] digit_val,
  output logic [NUM_DIGITS-1:0]   digit_dp,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err_pattern,
  output logic                    err_com
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

  logic [7:0]            seg_pin;
  logic [NUM_DIGITS-1:0] com_pin;

`ifdef SEG_ACTIVE_LOW_EN
  assign seg_pin = ~seg_in;
  assign com_pin = ~com_in;
`else
  assign seg_pin = seg_in;
  assign com_pin = com_in;
`endif

  logic [7:0]            r_seg_q;
  logic [NUM_DIGITS-1:0] r_com_q;
  logic                  chg_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  in_chg;

  // cnt_q counts how many cycles the registered copy has held its current value
  assign in_chg = ({seg_pin, com_pin} != {r_seg_q, r_com_q});

  always_comb begin
    if (in_chg)                cnt_d = CW'(1);
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_q <= '0;
      r_com_q <= '0;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      r_seg_q <= seg_pin;
      r_com_q <= com_pin;
      chg_q   <= in_chg;
      cnt_q   <= cnt_d;
    end
  end

  seg_state_e state_q, state_d;
  logic       capture;
  logic       com_blank;
  logic       cnt_full;

  assign com_blank = (r_com_q == '0);
  assign cnt_full  = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (!com_blank) begin
          if (cnt_full) begin
            capture = 1'b1;
            state_d = CAPTURED;
          end else begin
            state_d = WAIT_STABLE;
          end
        end
      end
      WAIT_STABLE: begin
        if (com_blank) begin
          state_d = IDLE;
        end else if (cnt_full) begin
          capture = 1'b1;
          state_d = CAPTURED;
        end
      end
      CAPTURED: begin
        // A single-cycle stability window captures a new value immediately
        if (chg_q) begin
          if (com_blank) begin
            state_d = IDLE;
          end else if (cnt_full) begin
            capture = 1'b1;
          end else begin
            state_d = WAIT_STABLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  logic [2:0] dec_val;
  logic       dec_legal;

  seg_to_bin u_seg_to_bin (
    .pat_i   (r_seg_q[7:1]),
    .val_o   (dec_val),
    .legal_o (dec_legal)
  );

  logic [3*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    fd_q, fd_d;
  logic                    ep_q, ep_d;
  logic                    ec_q, ec_d;

  always_comb begin
    val_d   = val_q;
    dp_d    = dp_q;
    valid_d = valid_q;
    fd_d    = (seen_q == ALL_SEEN);
    seen_d  = fd_d ? '0 : seen_q;
    ep_d    = err_clr ? 1'b0 : ep_q;
    ec_d    = err_clr ? 1'b0 : ec_q;
    if (capture) begin
      if ($onehot(r_com_q)) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (r_com_q[i]) begin
            seen_d[i] = 1'b1;
            if (dec_legal) begin
              val_d[3*i +: 3] = dec_val;
              dp_d[i]         = r_seg_q[SEG_DP_BIT];
              valid_d[i]      = 1'b1;
            end else begin
              valid_d[i] = 1'b0;
              ep_d       = 1'b1;
            end
          end
        end
      end else begin
        ec_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q   <= '0;
      dp_q    <= '0;
      valid_q <= '0;
      seen_q  <= '0;
      fd_q    <= 1'b0;
      ep_q    <= 1'b0;
      ec_q    <= 1'b0;
    end else begin
      val_q   <= val_d;
      dp_q    <= dp_d;
      valid_q <= valid_d;
      seen_q  <= seen_d;
      fd_q    <= fd_d;
      ep_q    <= ep_d;
      ec_q    <= ec_d;
    end
  end

  assign digit_val   = val_q;
  assign digit_dp    = dp_q;
  assign digit_valid = valid_q;
  assign frame_done  = fd_q;
  assign err_pattern = ep_q;
  assign err_com     = ec_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a run-length reference model predicts the
// full output state after every clock edge; a monitor pops and compares each cycle.
module tb_seg_scan_decoder;

  localparam int N = 4;
  localparam int S = 3;
  localparam int SW = 3*N + N + N + 3;

  typedef logic [SW-1:0] snap_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     seg_in = '0;
  logic [N-1:0]   com_in = '0;
  logic           err_clr = 1'b0;
  logic [3*N-1:0] digit_val;
  logic [N-1:0]   digit_dp;
  logic [N-1:0]   digit_valid;
  logic           frame_done;
  logic           err_pattern;
  logic           err_com;

  seg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .com_in      (com_in),
    .err_clr     (err_clr),
    .digit_val   (digit_val),
    .digit_dp    (digit_dp),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err_pattern (err_pattern),
    .err_com     (err_com)
  );

  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  int    fd_cnt = 0;
  snap_t exp_q[$];

  // Reference model: value last seen on the bus, how long it has been held, outputs
  logic [7:0]     m_seg;
  logic [N-1:0]   m_com;
  int             m_run;
  logic [3*N-1:0] m_val;
  logic [N-1:0]   m_dp, m_valid, m_seen;
  logic           m_fd, m_ep, m_ec;

  function automatic logic [7:0] enc(input int v);
    case (v)
      0: return 8'hFC;
      1: return 8'h60;
      2: return 8'hDA;
      3: return 8'hF2;
      4: return 8'h66;
      5: return 8'hB6;
      6: return 8'hBE;
      default: return 8'hE0;
    endcase
  endfunction

  function automatic int dec(input logic [6:0] p);
    logic [7:0] e;
    for (int v = 0; v < 8; v++) begin
      e = enc(v);
      if (e[7:1] == p) return v;
    end
    return -1;
  endfunction

  function automatic snap_t snap();
    return {m_val, m_dp, m_valid, m_fd, m_ep, m_ec};
  endfunction

  task automatic model_reset();
    m_seg = '0; m_com = '0; m_run = 0;
    m_val = '0; m_dp = '0; m_valid = '0; m_seen = '0;
    m_fd = 1'b0; m_ep = 1'b0; m_ec = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] s, input logic [N-1:0] c, input logic clr);
    logic         cap, new_p, new_c, fd_new;
    logic [N-1:0] seen;
    int           d;
    logic [2:0]   d3;
    cap    = (m_com != '0) && (m_run == S);
    fd_new = (m_seen == {N{1'b1}});
    seen   = fd_new ? '0 : m_seen;
    new_p  = 1'b0;
    new_c  = 1'b0;
    if (cap) begin
      if ($countones(m_com) == 1) begin
        for (int i = 0; i < N; i++) begin
          if (m_com[i]) begin
            seen[i] = 1'b1;
            d = dec(m_seg[7:1]);
            if (d >= 0) begin
              d3 = d[2:0];
              m_val[3*i +: 3] = d3;
              m_dp[i]    = m_seg[0];
              m_valid[i] = 1'b1;
            end else begin
              m_valid[i] = 1'b0;
              new_p = 1'b1;
            end
          end
        end
      end else begin
        new_c = 1'b1;
      end
    end
    m_ep   = new_p ? 1'b1 : (clr ? 1'b0 : m_ep);
    m_ec   = new_c ? 1'b1 : (clr ? 1'b0 : m_ec);
    m_fd   = fd_new;
    m_seen = seen;
    if ({s, c} != {m_seg, m_com}) m_run = 1;
    else if (m_run <= S) m_run++;
    m_seg = s;
    m_com = c;
  endtask

  task automatic drive(input logic [7:0] s, input logic [N-1:0] c, input logic clr);
`ifdef SEG_ACTIVE_LOW_EN
    seg_in = ~s;
    com_in = ~c;
`else
    seg_in = s;
    com_in = c;
`endif
    err_clr = clr;
  endtask

  task automatic step(input logic [7:0] s, input logic [N-1:0] c, input logic clr);
    rst_n = 1'b1;
    drive(s, c, clr);
    @(posedge clk);
    model_edge(s, c, clr);
    exp_q.push_back(snap());
    @(negedge clk);
    if (frame_done) fd_cnt++;
  endtask

  task automatic rst_step(input logic [7:0] s, input logic [N-1:0] c);
    rst_n = 1'b0;
    drive(s, c, 1'b0);
    @(posedge clk);
    model_reset();
    exp_q.push_back(snap());
    @(negedge clk);
  endtask

  task automatic hold(input logic [7:0] s, input logic [N-1:0] c, input int n);
    for (int i = 0; i < n; i++) step(s, c, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    snap_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {digit_val, digit_dp, digit_valid, frame_done, err_pattern, err_com};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL snapshot @%0t: got val=%h dp=%b valid=%b fd=%b ep=%b ec=%b, expected val=%h dp=%b valid=%b fd=%b ep=%b ec=%b",
                 $time, a[SW-1 -: 3*N], a[SW-3*N-1 -: N], a[N+2:3], a[2], a[1], a[0],
                 e[SW-1 -: 3*N], e[SW-3*N-1 -: N], e[N+2:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] c;
    logic [7:0]   s;
    int           a, b, kind, len;
    model_reset();
    @(negedge clk);

    rst_step(8'hFF, 4'b1111);
    rst_step(8'hDA, 4'b0011);
    rst_step(8'h02, 4'b0100);
    chk("reset_outputs", {digit_val, digit_dp, digit_valid, frame_done, err_pattern, err_com}, '0);

    for (int i = 0; i < 6; i++) begin
      step(8'hFC, 4'b0001, 1'b0);
      if (i == 2) chk("latency_before", digit_valid, 4'b0000);
      if (i == 3) chk("latency_at", digit_valid, 4'b0001);
    end
    chk("digit0_val", digit_val[2:0], 3'd0);

    for (int k = 0; k < 8; k++) step(((k / 2) % 2 != 0) ? 8'hDA : 8'h60, 4'b0010, 1'b0);
    chk("glitch_no_capture", digit_valid[1], 1'b0);
    hold(8'hDA, 4'b0010, 6);
    chk("glitch_digit1", digit_val[5:3], 3'd2);

    rst_step(8'h00, 4'b0000);
    fd_cnt = 0;
    hold(8'hE0, 4'b0001, 5);
    hold(8'hB6, 4'b0010, 5);
    hold(8'hF3, 4'b0100, 5);
    hold(8'h60, 4'b1000, 5);
    chk("frame_val", digit_val, 12'b001_011_101_111);
    chk("frame_dp", digit_dp, 4'b0100);
    chk("frame_done_once", fd_cnt, 1);

    hold(8'h02, 4'b0100, 6);
    chk("illegal_pat_err", err_pattern, 1'b1);
    chk("illegal_pat_valid", digit_valid[2], 1'b0);
    step(8'h02, 4'b0100, 1'b1);
    chk("err_pattern_clr", err_pattern, 1'b0);

    for (int i = 0; i < 6; i++) step(8'h60, 4'b0011, (i == S));
    chk("illegal_com_err", err_com, 1'b1);
    step(8'h60, 4'b0011, 1'b1);
    chk("err_com_clr", err_com, 1'b0);

    hold(8'h00, 4'b0000, 10);
    chk("blank_no_err", {err_pattern, err_com}, 2'b00);

    hold(8'hB6, 4'b1000, 2);
    rst_step(8'hB6, 4'b1000);
    chk("midreset_valid", digit_valid, 4'b0000);
    hold(8'hB6, 4'b1000, 5);
    chk("after_midreset", digit_val[11:9], 3'd5);

    for (int t = 0; t < 250; t++) begin
      kind = $urandom_range(0, 9);
      a = $urandom_range(0, N-1);
      c = '0;
      s = enc($urandom_range(0, 7)) | 8'($urandom_range(0, 1));
      if (kind <= 5) begin
        c[a] = 1'b1;
      end else if (kind == 8) begin
        b = (a + 1 + $urandom_range(0, N-2)) % N;
        c[a] = 1'b1;
        c[b] = 1'b1;
      end else if (kind == 9) begin
        c[a] = 1'b1;
        s = 8'($urandom_range(0, 255));
      end
      len = $urandom_range(1, 6);
      if ($urandom_range(0, 49) == 0) rst_step(s, c);
      for (int i = 0; i < len; i++) step(s, c, ($urandom_range(0, 9) == 0));
    end

    hold(8'h00, 4'b0000, 3);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side counterpart of the 3-bit-to-7-segment encoder. Monitors a time-multiplexed 7-segment bus (segment pattern plus one-hot digit select) and reconstructs the 3-bit value and decimal point shown on each digit. Filters transition glitches by requiring a stability window before capture, and flags illegal patterns and illegal digit selects. Used as an on-chip display self-check and as a bench-side scoreboard for the mole-game display path.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (width of com_in); legal range 1..8.
STABLE_CYCLES, 3, consecutive identical cycles of {com_in, seg_in} required before capture; must be >= 1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
seg_in  input  8  segment pattern; bit7=a, bit6=b, ... bit1=g, bit0=dp; 1 = lit
com_in  input  NUM_DIGITS  digit select; one-hot = digit active; all-zero = blanking
err_clr  input  1  synchronous clear of sticky error flags
digit_val  output  3*NUM_DIGITS  decoded value; digit i occupies bits [3i+2:3i]
digit_dp  output  NUM_DIGITS  captured dp bit per digit
digit_valid  output  NUM_DIGITS  digit holds a legal captured value
frame_done  output  1  one-cycle pulse when every digit has been captured since the previous pulse
err_pattern  output  1  sticky: a stable pattern matched no legal code
err_com  output  1  sticky: stable com_in had more than one bit set

Behaviour:
- Reset (async assert, sync-release usage): all outputs 0; stability counter 0; seen-mask 0; FSM to IDLE.
- Inputs are registered once (r_seg, r_com). All decisions use the registered copy, so capture latency = 1 register stage + STABLE_CYCLES cycles.
- Stability counter: increments while {r_seg, r_com} equals its previous-cycle value and saturates at STABLE_CYCLES. It resets to 1 on any change. Width = $clog2(STABLE_CYCLES+1).
- FSM states:
  - IDLE: waiting for a non-blank r_com.
  - WAIT_STABLE: counting. Any change restarts the count. r_com becoming zero returns to IDLE.
  - CAPTURED: exactly one capture has occurred for the current stable value. Stays here until {r_seg, r_com} changes, then goes to WAIT_STABLE, or to IDLE if blank. No repeat capture while the value is held.
- Transition into CAPTURED: on the cycle the counter reaches STABLE_CYCLES.
  - Legal one-hot com, digit i, legal pattern: digit_val[i] = code, digit_dp[i] = seg bit0, digit_valid[i] = 1, seen[i] = 1.
  - Illegal pattern (bits 7:1 not in the code set): digit_valid[i] = 0, digit_val[i] and digit_dp[i] unchanged, err_pattern = 1, seen[i] = 1.
  - Multi-hot com: no digit updated, err_com = 1, seen unchanged.
- Legal codes (bits 7:1 → value):
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3
  - 0110011→4, 1011011→5, 1011111→6, 1110000→7
  - dp is ignored for matching.
- frame_done: asserted the cycle after seen becomes all-ones. seen clears in the same cycle frame_done asserts. A capture landing on that same cycle is recorded into the cleared mask.
- err_clr and a new error in the same cycle: the error wins (flag stays 1).
- STABLE_CYCLES=1: capture on the first registered cycle of each new value.
- rst_n asserted mid-window: counter and partial state are discarded; no capture occurs.

Optional Feature:
SEG_ACTIVE_LOW_EN.
- Defined: seg_in and com_in are inverted at the input register, supporting common-anode boards (0 = lit / selected). All internal logic is unchanged.
- Undefined: active-high, as specified above.

Decomposition:
- Package seg_pkg holds:
  - the eight 7-bit code localparams (SEG_CODE_0..SEG_CODE_7)
  - SEG_DP_BIT = 0
  - the fsm state enum (IDLE, WAIT_STABLE, CAPTURED)
- Sub-module seg_to_bin (combinational): input 7-bit pattern; outputs 3-bit value and a legal flag. It is instantiated once on r_seg.
- The top level contains the FSM, counter, per-digit capture registers, seen-mask and error flags.

Test Plan:
- Reset: drive patterns with rst_n=0 → all outputs 0. Release and hold com=0001, seg=0xFC for 4 cycles → digit_val[2:0]=0, digit_valid=0001, captured on cycle 1+3.
- Glitch filter: com=0010 with seg toggling 0x60/0xDA every 2 cycles (STABLE_CYCLES=3) → no capture. Then hold 0xDA → digit1=2 captured exactly once.
- Full frame: scan digits 0..3 showing 7,5,3,1 with dp on digit2, 5 cycles each → frame_done pulses once after digit3. Required results: digit_val=001_011_101_111, digit_dp=0100.
- Illegal pattern: com=0100, seg=0x02 held → err_pattern=1, digit_valid[2]=0. err_clr pulse → err_pattern=0.
- Illegal com: com=0011, seg=0x60 held → err_com=1, no digit_valid change. Also assert err_clr on the capture cycle → err_com remains 1.
- Blanking: com=0000 between digits for 10 cycles → FSM stays IDLE, no captures, no errors.
